// File: rtl/bit_alu_pkg.sv
// rtl/bit_alu_pkg.sv - shared opcode enum, width default and result struct for bit_alu_16
package bit_alu_pkg;

   localparam int ALU_WIDTH = 16;

   typedef enum logic [2:0] {
      OP_ADD = 3'b000,
      OP_SUB = 3'b001,
      OP_AND = 3'b010,
      OP_OR  = 3'b011,
      OP_XOR = 3'b100,
      OP_NOT = 3'b101,
      OP_SHL = 3'b110,
      OP_SHR = 3'b111
   } alu_op_e;

   // carry holds carry-out, borrow or the bit shifted out; data is the result word
   typedef struct packed {
      logic                 carry;
      logic [ALU_WIDTH-1:0] data;
   } alu_res_t;

endpackage

// File: rtl/bit_alu_addsub.sv
// rtl/bit_alu_addsub.sv - combinational add/subtract with carry or borrow in the extra top bit
module bit_alu_addsub
   import bit_alu_pkg::*;
#(
   parameter int WIDTH = ALU_WIDTH
) (
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             sub,
   output logic [WIDTH:0]   result
);

   // Zero-extending both operands makes bit WIDTH the carry on add and the
   // borrow (a < b, unsigned) on subtract, since the difference wraps below zero.
   assign result = sub ? ({1'b0, a} - {1'b0, b}) : ({1'b0, a} + {1'b0, b});

endmodule

// File: rtl/bit_alu_16.sv
// rtl/bit_alu_16.sv - registered 8-operation ALU; optional flags under BIT_ALU_FLAGS_EN
module bit_alu_16
   import bit_alu_pkg::*;
#(
   parameter int WIDTH = ALU_WIDTH
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic [2:0]       alu_in,
   output logic [WIDTH-1:0] alu_out,
   output logic [WIDTH:0]   carryout,
   output logic             out_valid
`ifdef BIT_ALU_FLAGS_EN
   ,
   output logic             zero,
   output logic             negative,
   output logic             overflow
`endif
);

   alu_op_e        op;
   logic [WIDTH:0] sum_diff;
   alu_res_t       res_nxt;
   alu_res_t       res_q;
   logic           valid_q;

   assign op = alu_op_e'(alu_in);

   bit_alu_addsub #(
      .WIDTH (WIDTH)
   ) u_addsub (
      .a      (a),
      .b      (b),
      .sub    (op == OP_SUB),
      .result (sum_diff)
   );

   // Select the next extended result; logic ops leave the carry bit clear
   always_comb begin
      res_nxt = '0;
      unique case (op)
         OP_ADD,
         OP_SUB: res_nxt = sum_diff;
         OP_AND: res_nxt.data = a & b;
         OP_OR:  res_nxt.data = a | b;
         OP_XOR: res_nxt.data = a ^ b;
         OP_NOT: res_nxt.data = ~a;
         OP_SHL: res_nxt = {a[WIDTH-1], a[WIDTH-2:0], 1'b0};
         OP_SHR: res_nxt = {a[0], 1'b0, a[WIDTH-1:1]};
      endcase
   end

   // Capture the result on in_valid and hold it otherwise; out_valid pulses per capture
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         res_q   <= '0;
         valid_q <= 1'b0;
      end else begin
         valid_q <= in_valid;
         if (in_valid) begin
            res_q <= res_nxt;
         end
      end
   end

   assign carryout  = res_q;
   assign alu_out   = res_q.data;
   assign out_valid = valid_q;

`ifdef BIT_ALU_FLAGS_EN
   logic ovf_nxt;

   // Signed overflow only has meaning for the arithmetic opcodes
   always_comb begin
      ovf_nxt = 1'b0;
      if (op == OP_ADD) begin
         ovf_nxt = (a[WIDTH-1] == b[WIDTH-1]) && (res_nxt.data[WIDTH-1] != a[WIDTH-1]);
      end else if (op == OP_SUB) begin
         ovf_nxt = (a[WIDTH-1] != b[WIDTH-1]) && (res_nxt.data[WIDTH-1] != a[WIDTH-1]);
      end
   end

   // Flags are captured alongside the result so they always describe alu_out
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         zero     <= 1'b0;
         negative <= 1'b0;
         overflow <= 1'b0;
      end else if (in_valid) begin
         zero     <= (res_nxt.data == '0);
         negative <= res_nxt.data[WIDTH-1];
         overflow <= ovf_nxt;
      end
   end
`endif

endmodule

// File: tb/tb_bit_alu_16.sv
// tb/tb_bit_alu_16.sv - self-checking bench for bit_alu_16; flag checks under BIT_ALU_FLAGS_EN
module tb_bit_alu_16;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        in_valid = 1'b0;
   logic [15:0] a = '0;
   logic [15:0] b = '0;
   logic [2:0]  alu_in = '0;
   logic [15:0] alu_out;
   logic [16:0] carryout;
   logic        out_valid;
`ifdef BIT_ALU_FLAGS_EN
   logic        zero;
   logic        negative;
   logic        overflow;
`endif

   int          n_checks = 0;
   int          n_passed = 0;

   logic [16:0] exp_r = '0;
   logic        exp_v = 1'b0;
   logic        exp_z = 1'b0;
   logic        exp_n = 1'b0;
   logic        exp_o = 1'b0;

   logic [16:0] sweep_exp [8] = '{17'h1AAA9, 17'h1AAAB, 17'h0AAAA, 17'h0FFFF,
                                  17'h05555, 17'h05555, 17'h15554, 17'h05555};

   bit_alu_16 dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .a         (a),
      .b         (b),
      .alu_in    (alu_in),
      .alu_out   (alu_out),
      .carryout  (carryout),
      .out_valid (out_valid)
`ifdef BIT_ALU_FLAGS_EN
      ,
      .zero      (zero),
      .negative  (negative),
      .overflow  (overflow)
`endif
   );

   always #5 clk = ~clk;

   function automatic logic [16:0] ref_alu(input int unsigned x, input int unsigned y, input int op);
      int unsigned r;
      case (op)
         0: r = x + y;
         1: r = ((x - y) & 32'hFFFF) | ((x < y) ? 32'h10000 : 32'h0);
         2: r = x & y;
         3: r = x | y;
         4: r = x ^ y;
         5: r = (~x) & 32'hFFFF;
         6: r = (x * 2) & 32'h1FFFF;
         default: r = (x / 2) | ((x % 2) * 32'h10000);
      endcase
      return r[16:0];
   endfunction

   function automatic logic ref_ovf(input int unsigned x, input int unsigned y, input int op);
      int sx, sy, s;
      sx = (x >= 32768) ? int'(x) - 65536 : int'(x);
      sy = (y >= 32768) ? int'(y) - 65536 : int'(y);
      if (op == 0)      s = sx + sy;
      else if (op == 1) s = sx - sy;
      else              s = 0;
      return (s > 32767) || (s < -32768);
   endfunction

   task automatic check(input string tag, input logic [16:0] obs, input logic [16:0] exp);
      n_checks++;
      assert (obs === exp) n_passed++;
      else $error("FAIL %s observed=%05h expected=%05h", tag, obs, exp);
   endtask

   task automatic check_outputs(input string tag);
      check({tag, ".carryout"}, carryout, exp_r);
      check({tag, ".alu_out"}, {1'b0, alu_out}, {1'b0, exp_r[15:0]});
      check({tag, ".out_valid"}, {16'b0, out_valid}, {16'b0, exp_v});
`ifdef BIT_ALU_FLAGS_EN
      check({tag, ".zero"}, {16'b0, zero}, {16'b0, exp_z});
      check({tag, ".negative"}, {16'b0, negative}, {16'b0, exp_n});
      check({tag, ".overflow"}, {16'b0, overflow}, {16'b0, exp_o});
`endif
   endtask

   // Apply one cycle of inputs, advance the reference, sample 1 time unit after the edge
   task automatic step(input logic v, input logic [15:0] ai, input logic [15:0] bi, input logic [2:0] op);
      in_valid = v;
      a = ai;
      b = bi;
      alu_in = op;
      @(posedge clk);
      #1;
      exp_v = v;
      if (v) begin
         exp_r = ref_alu(ai, bi, int'(op));
         exp_z = (exp_r[15:0] == 16'h0);
         exp_n = exp_r[15];
         exp_o = ref_ovf(ai, bi, int'(op));
      end
   endtask

   task automatic clear_model();
      exp_r = '0;
      exp_v = 1'b0;
      exp_z = 1'b0;
      exp_n = 1'b0;
      exp_o = 1'b0;
   endtask

   initial begin
      repeat (2) @(posedge clk);
      #1;
      check_outputs("reset_state");
      rst_n = 1'b1;

      for (int i = 0; i < 8; i++) begin
         step(1'b1, 16'hAAAA, 16'hFFFF, 3'(i));
         check($sformatf("sweep_op%0d.table", i), carryout, sweep_exp[i]);
         check_outputs($sformatf("sweep_op%0d", i));
      end

      step(1'b1, 16'hFFFF, 16'h0001, 3'b000);
      check("add_carry_edge", carryout, 17'h10000);
      step(1'b1, 16'h0000, 16'h0001, 3'b001);
      check("sub_borrow_edge", carryout, 17'h1FFFF);
      step(1'b1, 16'h1234, 16'h1234, 3'b001);
      check("sub_equal_edge", carryout, 17'h00000);
      check_outputs("sub_equal_edge");

      for (int i = 0; i < 3; i++) begin
         step(1'b0, 16'($urandom), 16'($urandom), 3'($urandom));
         check($sformatf("hold%0d.carryout", i), carryout, 17'h00000);
         check_outputs($sformatf("hold%0d", i));
      end

      for (int i = 0; i < 200; i++) begin
         step(1'b1, 16'($urandom), 16'($urandom), 3'($urandom));
         check_outputs("b2b_random");
      end

      for (int i = 0; i < 200; i++) begin
         step(1'($urandom_range(0, 1)), 16'($urandom), 16'($urandom), 3'($urandom));
         check_outputs("mixed_random");
      end

      step(1'b1, 16'h1357, 16'h0246, 3'b011);
      check_outputs("pre_reset");
      in_valid = 1'b1;
      a = 16'hFFFF;
      b = 16'hFFFF;
      alu_in = 3'b000;
      #2;
      rst_n = 1'b0;
      #1;
      clear_model();
      check_outputs("async_reset");
      @(posedge clk);
      #1;
      check_outputs("reset_discard");
      rst_n = 1'b1;
      for (int i = 0; i < 2; i++) begin
         step(1'b0, 16'($urandom), 16'($urandom), 3'($urandom));
         check_outputs("post_reset_idle");
      end

`ifdef BIT_ALU_FLAGS_EN
      step(1'b1, 16'h7FFF, 16'h0001, 3'b000);
      check("flag_add_ovf.data", carryout, 17'h08000);
      check("flag_add_ovf.overflow", {16'b0, overflow}, 17'h1);
      check("flag_add_ovf.negative", {16'b0, negative}, 17'h1);
      step(1'b1, 16'h5555, 16'h5555, 3'b100);
      check("flag_xor_zero", {16'b0, zero}, 17'h1);
      step(1'b1, 16'hFFFF, 16'h8000, 3'b010);
      check("flag_and_no_ovf", {16'b0, overflow}, 17'h0);
`endif

      $display("%0d/%0d checks passed", n_passed, n_checks);
      $finish;
   end

endmodule

// File: doc/bit_alu_16.md
Name: bit_alu_16

Overview:
- Registered 16-bit, 8-operation ALU: two operands plus a 3-bit opcode in, 16-bit result plus a 17-bit extended result out.
- Datapath leaf block for the 16-bit processing path; operands sampled on in_valid, result presented one clock later.
- Purely synchronous datapath apart from the asynchronous reset.

Parameters:
- WIDTH, 16, operand/result width; carryout is WIDTH+1 bits. Only 16 is verified.

Ports:
- clk  input  1  single clock, rising edge
- rst_n  input  1  asynchronous active-low reset
- in_valid  input  1  sample a, b, alu_in this cycle
- a  input  16  operand A
- b  input  16  operand B
- alu_in  input  3  opcode
- alu_out  output  16  registered result, equal to carryout[15:0]
- carryout  output  17  registered extended result: bit 16 is carry/borrow/shifted-out bit
- out_valid  output  1  one-cycle pulse, results updated

Behaviour:
- Reset is asynchronous on rst_n low and releases synchronously to clk.
  - During reset: alu_out=0, carryout=0, out_valid=0.
- Latency: in_valid high at edge N -> alu_out/carryout updated and out_valid=1 after edge N.
- in_valid low -> alu_out/carryout hold their previous values, out_valid=0.
- Back-to-back in_valid is supported, one result per cycle; no backpressure.
- All 8 opcodes are defined, so no illegal-opcode case exists. Opcode table, where R is the 17-bit carryout:
  - 000 ADD: R = {1'b0,a} + {1'b0,b}; R[16] is the carry out.
  - 001 SUB: R[15:0] = a - b (mod 2^16); R[16] = borrow = (a < b, unsigned).
  - 010 AND: R = {0, a & b}
  - 011 OR: R = {0, a | b}
  - 100 XOR: R = {0, a ^ b}
  - 101 NOT: R = {0, ~a}; b is ignored.
  - 110 SHL: R = {a[15], a[14:0], 1'b0}; logical shift left by 1.
  - 111 SHR: R = {a[0], 1'b0, a[15:1]}; logical shift right by 1, bit 16 holds the shifted-out a[0].
- alu_out is always carryout[15:0]; the two outputs never disagree.
- Boundaries:
  - ADD FFFF+0001 -> 10000.
  - SUB 0000-0001 -> 1FFFF.
  - SUB with a==b -> 00000.
- rst_n asserted mid-stream clears the outputs immediately; an in-flight sample is discarded.

Optional Feature:
- Macro: BIT_ALU_FLAGS_EN.
- When defined, three extra registered outputs are added, each updated with alu_out and reset to 0:
  - zero (alu_out==0)
  - negative (alu_out[15])
  - overflow: signed overflow, ADD/SUB only, 0 for all other opcodes.
    - ADD: a[15]==b[15] && alu_out[15]!=a[15]
    - SUB: a[15]!=b[15] && alu_out[15]!=a[15]
- When undefined, these ports and their logic are absent and behaviour is otherwise identical.

Decomposition:
- Shared package bit_alu_pkg holds:
  - the opcode enum (OP_ADD=3'b000 ... OP_SHR=3'b111)
  - WIDTH default
  - a result struct {carry, data}
- One sub-module, bit_alu_addsub, is natural: combinational 17-bit add/subtract with borrow output.
- Top level holds the logic/shift mux, output registers and valid pipeline.

Test Plan:
- Reset: assert rst_n=0 mid-run -> alu_out=0000, carryout=00000, out_valid=0 immediately; hold with in_valid=0 after release -> outputs stay 0.
- Sweep with a=AAAA, b=FFFF, alu_in 000..111, in_valid=1 -> carryout per opcode:
  - 000 -> 1AAA9
  - 001 -> 1AAAB
  - 010 -> 0AAAA
  - 011 -> 0FFFF
  - 100 -> 05555
  - 101 -> 05555
  - 110 -> 15554
  - 111 -> 05555
  - in every case alu_out = low 16 bits, one cycle later.
- Carry/borrow edges:
  - ADD FFFF+0001 -> 10000
  - SUB 0000-0001 -> 1FFFF
  - SUB 1234-1234 -> 00000
- Hold and back-to-back behaviour:
  - in_valid low for 3 cycles while inputs change -> outputs unchanged, out_valid=0.
  - Back-to-back valids -> a new result every cycle, out_valid stays 1.
- Flags (BIT_ALU_FLAGS_EN):
  - ADD 7FFF+0001 -> 8000, overflow=1, negative=1.
  - XOR 5555^5555 -> zero=1.
  - AND -> overflow=0.
